// File: rtl/audio_pkg.sv
// Shared types and constants for the flash-backed audio sample fetcher.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    WAIT_T0,
    WAIT_T1,
    ADVANCE
  } fetch_state_t;

  localparam int               FLASH_ADDR_W   = 23;
  localparam logic [22:0]      FLASH_MAX_ADDR = 23'h7FFFF;
  localparam int               SAMPLE_W       = 16;

  // Select one 16-bit half of a flash word; upper=1 gives bits [31:16].
  function automatic logic [SAMPLE_W-1:0] pick_half(input logic [2*SAMPLE_W-1:0] word,
                                                   input logic upper);
    return upper ? word[2*SAMPLE_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/wrap_addr_counter.sv
// Word-address counter over 0..MAX_ADDR that wraps in both directions and can
// jump to the start of the range for the current direction.
module wrap_addr_counter #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              step,
  input  logic              backward,
  output logic [ADDR_W-1:0] addr
);

  // The start of the play range is the top address when playing backward.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load_start) begin
      addr <= backward ? MAX_ADDR : '0;
    end else if (step) begin
      if (backward) begin
        addr <= (addr == '0) ? MAX_ADDR : addr - 1'b1;
      end else begin
        addr <= (addr == MAX_ADDR) ? '0 : addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_sample_fetch.sv
// Reads 32-bit flash words and plays them out as two 16-bit samples, one per
// sample_tick, with pause, restart, direction control and tick-loss detection.
module audio_sample_fetch
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = FLASH_MAX_ADDR
) (
  input  logic                out_clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                play_en,
  input  logic                direction,
  input  logic                restart,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic                flash_waitrequest,
  input  logic [31:0]         flash_readdata,
  input  logic                flash_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid,
  output logic                overrun
);

  fetch_state_t state, state_next;

  logic        tick_pending;
  logic        restart_pending;
  logic        word_backward;
  logic [31:0] word_reg;
  logic        tick_any;
  logic        consume;
  logic        restart_now;
  logic        load_start;
  logic        step_addr;

  assign tick_any    = sample_tick | tick_pending;
  assign consume     = ((state == WAIT_T0) || (state == WAIT_T1)) && tick_any;
  // A restart while parked and paused takes effect at once rather than waiting for ADVANCE.
  assign restart_now = restart && (state == IDLE) && !play_en;
  assign load_start  = restart_now || ((state == ADVANCE) && restart_pending);
  assign step_addr   = (state == ADVANCE) && !restart_pending;

  wrap_addr_counter #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr (
    .clk        (out_clk),
    .reset      (reset),
    .load_start (load_start),
    .step       (step_addr),
    .backward   (direction),
    .addr       (flash_address)
  );

  always_ff @(posedge out_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (play_en) state_next = FETCH;
      FETCH:     if (!flash_waitrequest) state_next = WAIT_DATA;
      WAIT_DATA: if (flash_readdatavalid) state_next = WAIT_T0;
      WAIT_T0:   if (tick_any) state_next = WAIT_T1;
      WAIT_T1:   if (tick_any) state_next = ADVANCE;
      ADVANCE:   state_next = play_en ? FETCH : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    flash_read = (state == FETCH);
  end

  // The word's play order is fixed at its first sample so a mid-word direction flip cannot reorder it.
  always_ff @(posedge out_clk) begin
    if (reset) begin
      word_reg        <= '0;
      word_backward   <= 1'b0;
      audio_sample    <= '0;
      sample_valid    <= 1'b0;
      tick_pending    <= 1'b0;
      restart_pending <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if ((state == WAIT_DATA) && flash_readdatavalid) word_reg <= flash_readdata;
      if ((state == WAIT_T0) && tick_any) begin
        audio_sample  <= pick_half(word_reg, direction);
        word_backward <= direction;
        sample_valid  <= 1'b1;
      end
      if ((state == WAIT_T1) && tick_any) begin
        audio_sample <= pick_half(word_reg, !word_backward);
        sample_valid <= 1'b1;
      end
      if (consume) begin
        if (tick_pending) tick_pending <= sample_tick;
      end else if ((state != IDLE) && sample_tick) begin
        if (tick_pending) overrun <= 1'b1;
        else              tick_pending <= 1'b1;
      end
      if ((state == ADVANCE) && restart_pending) restart_pending <= 1'b0;
      if (restart && !restart_now) restart_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Directed bench for audio_sample_fetch with a two-cycle-latency flash model
// and hand-computed sample/address expectations.
module tb_audio_sample_fetch;

  logic        out_clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        play_en;
  logic        direction;
  logic        restart;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        overrun;

  int          total_count  = 0;
  int          bad_count    = 0;
  int          accept_count = 0;
  int          valid_count  = 0;
  int          resp_cnt     = 0;
  logic [22:0] resp_addr    = '0;
  int          vc0;
  int          ac0;

  audio_sample_fetch dut (
    .out_clk             (out_clk),
    .reset               (reset),
    .sample_tick         (sample_tick),
    .play_en             (play_en),
    .direction           (direction),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid),
    .overrun             (overrun)
  );

  always #5 out_clk = ~out_clk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    case (a)
      23'h00000: return 32'hBBBB_AAAA;
      23'h00001: return 32'h2222_1111;
      23'h7FFFF: return 32'h1234_5678;
      23'h7FFFE: return 32'hCCCC_DDDD;
      default:   return {9'h0, a};
    endcase
  endfunction

  // Flash model: data returns on the second rising edge after the accept edge.
  always begin
    @(negedge out_clk);
    #1;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = mem_word(resp_addr);
      end
    end
    if (sample_valid) valid_count++;
    if (flash_read && !flash_waitrequest && !reset) begin
      accept_count++;
      resp_cnt  = 2;
      resp_addr = flash_address;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pe, input logic dir);
    play_en   = pe;
    direction = dir;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge out_clk);
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge out_clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge out_clk);
    restart = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    while (flash_read !== 1'b1 && n < 20) begin
      @(negedge out_clk);
      n++;
    end
    checkOutput({tag, "_read_seen"}, {31'h0, flash_read}, 32'h1);
  endtask

  // Plays out a word whose read is visible at the current negedge, then parks.
  task automatic finish_word();
    cycles(4);
    pulse_tick();
    pulse_tick();
    cycles(2);
  endtask

  initial begin
    reset             = 1'b1;
    sample_tick       = 1'b0;
    restart           = 1'b0;
    flash_waitrequest = 1'b0;
    applyStimulus(1'b0, 1'b0);
    cycles(3);
    checkOutput("rst_read",    {31'h0, flash_read},   32'h0);
    checkOutput("rst_addr",    {9'h0, flash_address}, 32'h0);
    checkOutput("rst_sample",  {16'h0, audio_sample}, 32'h0);
    checkOutput("rst_valid",   {31'h0, sample_valid}, 32'h0);
    checkOutput("rst_overrun", {31'h0, overrun},      32'h0);
    reset = 1'b0;
    cycles(1);

    // Forward play of word 0
    vc0 = valid_count;
    applyStimulus(1'b1, 1'b0);
    wait_read("fwd");
    checkOutput("fwd_addr0", {9'h0, flash_address}, 32'h0);
    cycles(4);
    pulse_tick();
    checkOutput("fwd_s0",     {16'h0, audio_sample}, 32'hAAAA);
    checkOutput("fwd_v0",     {31'h0, sample_valid}, 32'h1);
    cycles(1);
    checkOutput("fwd_v0_end", {31'h0, sample_valid}, 32'h0);
    pulse_tick();
    checkOutput("fwd_s1",     {16'h0, audio_sample}, 32'hBBBB);
    checkOutput("fwd_v1",     {31'h0, sample_valid}, 32'h1);
    cycles(1);
    checkOutput("fwd_next_read", {31'h0, flash_read},   32'h1);
    checkOutput("fwd_next_addr", {9'h0, flash_address}, 32'h1);
    checkOutput("fwd_pulses",    valid_count - vc0,     32'd2);
    applyStimulus(1'b0, 1'b0);
    finish_word();

    // Backward play from the top of the range
    applyStimulus(1'b0, 1'b1);
    pulse_restart();
    checkOutput("bwd_restart_addr", {9'h0, flash_address}, 32'h7FFFF);
    applyStimulus(1'b1, 1'b1);
    wait_read("bwd");
    checkOutput("bwd_addr", {9'h0, flash_address}, 32'h7FFFF);
    cycles(4);
    pulse_tick();
    checkOutput("bwd_s0", {16'h0, audio_sample}, 32'h1234);
    pulse_tick();
    checkOutput("bwd_s1", {16'h0, audio_sample}, 32'h5678);
    cycles(1);
    checkOutput("bwd_next_addr", {9'h0, flash_address}, 32'h7FFFE);
    checkOutput("bwd_next_read", {31'h0, flash_read},   32'h1);
    applyStimulus(1'b0, 1'b1);
    finish_word();

    // Forward wrap from MAX_ADDR, then a pending restart applied backward
    pulse_restart();
    applyStimulus(1'b1, 1'b0);
    wait_read("fwrap");
    checkOutput("fwrap_addr", {9'h0, flash_address}, 32'h7FFFF);
    cycles(4);
    pulse_tick();
    checkOutput("fwrap_s0", {16'h0, audio_sample}, 32'h5678);
    pulse_tick();
    checkOutput("fwrap_s1", {16'h0, audio_sample}, 32'h1234);
    cycles(1);
    checkOutput("fwrap_next_addr", {9'h0, flash_address}, 32'h0);
    pulse_restart();
    applyStimulus(1'b0, 1'b0);
    cycles(3);
    pulse_tick();
    checkOutput("midflip_s0", {16'h0, audio_sample}, 32'hAAAA);
    applyStimulus(1'b0, 1'b1);
    pulse_tick();
    checkOutput("midflip_s1", {16'h0, audio_sample}, 32'hBBBB);
    cycles(1);
    checkOutput("pend_restart_addr", {9'h0, flash_address}, 32'h7FFFF);
    checkOutput("pend_restart_idle", {31'h0, flash_read},   32'h0);

    // Waitrequest stall with play_en dropping
    applyStimulus(1'b0, 1'b0);
    pulse_restart();
    checkOutput("stall_start_addr", {9'h0, flash_address}, 32'h0);
    flash_waitrequest = 1'b1;
    ac0 = accept_count;
    applyStimulus(1'b1, 1'b0);
    wait_read("stall");
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      checkOutput("stall_read_held", {31'h0, flash_read},   32'h1);
      checkOutput("stall_addr_held", {9'h0, flash_address}, 32'h0);
    end
    flash_waitrequest = 1'b0;
    cycles(4);
    pulse_tick();
    checkOutput("stall_s0", {16'h0, audio_sample}, 32'hAAAA);
    pulse_tick();
    checkOutput("stall_s1", {16'h0, audio_sample}, 32'hBBBB);
    cycles(2);
    checkOutput("stall_idle_read", {31'h0, flash_read},   32'h0);
    checkOutput("stall_idle_addr", {9'h0, flash_address}, 32'h1);
    checkOutput("stall_one_read",  accept_count - ac0,    32'd1);

    // Two early ticks: one held pending, the second lost
    vc0 = valid_count;
    applyStimulus(1'b1, 1'b0);
    wait_read("ovr");
    applyStimulus(1'b0, 1'b0);
    cycles(1);
    sample_tick = 1'b1;
    cycles(2);
    sample_tick = 1'b0;
    checkOutput("ovr_flag",       {31'h0, overrun},      32'h1);
    checkOutput("ovr_no_early_v", {31'h0, sample_valid}, 32'h0);
    cycles(1);
    checkOutput("ovr_v",          {31'h0, sample_valid}, 32'h1);
    checkOutput("ovr_s0",         {16'h0, audio_sample}, 32'h1111);
    cycles(1);
    checkOutput("ovr_v_once",     {31'h0, sample_valid}, 32'h0);
    checkOutput("ovr_pulses",     valid_count - vc0,     32'd1);
    pulse_tick();
    checkOutput("ovr_s1",         {16'h0, audio_sample}, 32'h2222);
    cycles(2);

    // Single early tick after a reset clears overrun
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    checkOutput("clr_overrun", {31'h0, overrun},      32'h0);
    checkOutput("clr_addr",    {9'h0, flash_address}, 32'h0);
    applyStimulus(1'b1, 1'b0);
    wait_read("early");
    applyStimulus(1'b0, 1'b0);
    cycles(1);
    sample_tick = 1'b1;
    cycles(1);
    sample_tick = 1'b0;
    cycles(1);
    checkOutput("early_entry_v", {31'h0, sample_valid}, 32'h0);
    cycles(1);
    checkOutput("early_v",       {31'h0, sample_valid}, 32'h1);
    checkOutput("early_s0",      {16'h0, audio_sample}, 32'hAAAA);
    checkOutput("early_no_ovr",  {31'h0, overrun},      32'h0);
    pulse_tick();
    checkOutput("early_s1",      {16'h0, audio_sample}, 32'hBBBB);
    cycles(2);

    // Reset while a read is outstanding; the late data must be ignored
    applyStimulus(1'b1, 1'b0);
    wait_read("mrst");
    applyStimulus(1'b0, 1'b0);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    vc0 = valid_count;
    checkOutput("mrst_read",    {31'h0, flash_read},   32'h0);
    checkOutput("mrst_addr",    {9'h0, flash_address}, 32'h0);
    checkOutput("mrst_sample",  {16'h0, audio_sample}, 32'h0);
    checkOutput("mrst_valid",   {31'h0, sample_valid}, 32'h0);
    checkOutput("mrst_overrun", {31'h0, overrun},      32'h0);
    cycles(3);
    checkOutput("mrst_late_sample", {16'h0, audio_sample}, 32'h0);
    checkOutput("mrst_late_read",   {31'h0, flash_read},   32'h0);

    // Ticks while parked are ignored
    pulse_tick();
    pulse_tick();
    cycles(2);
    checkOutput("idle_tick_overrun", {31'h0, overrun},      32'h0);
    checkOutput("idle_tick_sample",  {16'h0, audio_sample}, 32'h0);
    checkOutput("mrst_no_pulses",    valid_count - vc0,     32'd0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
